// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: data length, counter widths, FSM state encoding
// and the parity helper.
package uart_rx_pkg;

  localparam int unsigned DATA_LEN  = 8;
  localparam int unsigned BIT_CTR_W = 3;

  // 3-bit state encodings; ST_PARITY is only reachable when UART_RX_PARITY_EN is defined
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_WAIT   = 3'd5
  } rx_state_e;

  // Even-parity bit for a data word (xor of all bits)
  function automatic logic even_parity(input logic [DATA_LEN-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; resets to 1 (idle line).
// Ports:
//   clk_i   - destination clock
//   rst_n_i - asynchronous active-low reset
//   d_i     - asynchronous input
//   q_o     - synchronised output (2-cycle latency)
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises the serial line, detects the start bit, samples each bit at
// mid-bit and presents received bytes with a one-cycle valid strobe. Framing errors (stop
// bit low) give a one-cycle frame_err_o strobe; a held-low line (break) gives exactly one.
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit and parity_err_o.
// Ports:
//   clk_i        - clock, all logic on rising edge
//   rst_n_i      - asynchronous active-low reset
//   rx_i         - serial line, idle high, asynchronous
//   data_o       - last good byte, LSB received first
//   data_o_v     - 1-cycle strobe, data_o updated
//   frame_err_o  - 1-cycle strobe, stop bit sampled low
//   parity_err_o - (UART_RX_PARITY_EN only) 1-cycle strobe, parity mismatch
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                rx_i,
  output logic [DATA_LEN-1:0] data_o,
  output logic                data_o_v,
`ifdef UART_RX_PARITY_EN
  output logic                parity_err_o,
`endif
  output logic                frame_err_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  logic                 rx_s;
  rx_state_e            state_q;
  logic [CW-1:0]        clk_ctr_q;
  logic [BIT_CTR_W-1:0] bit_ctr_q;
  logic [DATA_LEN-1:0]  shift_q;
  logic [DATA_LEN-1:0]  data_q;
  logic                 data_v_q;
  logic                 frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_q;
  logic                 parity_err_q;
`endif

  uart_rx_sync u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (rx_i),
    .q_o     (rx_s)
  );

  wire mid_start = (clk_ctr_q == CW'(CLKS_PER_BIT/2 - 1));
  wire bit_end   = (clk_ctr_q == CW'(CLKS_PER_BIT - 1));

  // Receive FSM, counters, shift register and registered strobes
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      clk_ctr_q    <= '0;
      bit_ctr_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      data_v_q     <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      data_v_q    <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          clk_ctr_q <= '0;
          if (!rx_s) state_q <= ST_START;
        end
        ST_START: begin
          if (mid_start) begin
            clk_ctr_q <= '0;
            // A start bit that is already gone at mid-bit is a glitch
            state_q   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            clk_ctr_q <= clk_ctr_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            clk_ctr_q <= '0;
            shift_q   <= {rx_s, shift_q[DATA_LEN-1:1]};
            if (bit_ctr_q == BIT_CTR_W'(DATA_LEN - 1)) begin
              bit_ctr_q <= '0;
`ifdef UART_RX_PARITY_EN
              state_q   <= ST_PARITY;
`else
              state_q   <= ST_STOP;
`endif
            end else begin
              bit_ctr_q <= bit_ctr_q + BIT_CTR_W'(1);
            end
          end else begin
            clk_ctr_q <= clk_ctr_q + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            clk_ctr_q <= '0;
            par_q     <= rx_s;
            state_q   <= ST_STOP;
          end else begin
            clk_ctr_q <= clk_ctr_q + CW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            clk_ctr_q <= '0;
            if (rx_s) begin
              // Back to idle at mid-stop so an immediate next start edge is caught
              state_q <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
              if (even_parity(shift_q) != par_q) begin
                parity_err_q <= 1'b1;
              end else begin
                data_q   <= shift_q;
                data_v_q <= 1'b1;
              end
`else
              data_q   <= shift_q;
              data_v_q <= 1'b1;
`endif
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_WAIT;
            end
          end else begin
            clk_ctr_q <= clk_ctr_q + CW'(1);
          end
        end
        ST_WAIT: begin
          clk_ctr_q <= '0;
          if (rx_s) state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          clk_ctr_q <= '0;
          bit_ctr_q <= '0;
        end
      endcase
    end
  end

  assign data_o      = data_q;
  assign data_o_v    = data_v_q;
  assign frame_err_o = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule
